// File: rtl/adc_if.sv
// Parallel ADC pins as seen between the sequencer (master) and the ADC model (slave).
// Pure wiring, no latency.
// No backpressure: the sequencer paces all traffic with CONVST/RD/PD strobes.
interface adc_if;
    logic       ADC_CONVST;
    logic       ADC_RD;
    logic       ADC_PD;
    logic       ADC_EOC;
    logic [7:0] Data;

    modport master (output ADC_CONVST, ADC_RD, ADC_PD, input ADC_EOC, Data);
    modport slave  (input ADC_CONVST, ADC_RD, ADC_PD, output ADC_EOC, Data);
endinterface

// File: rtl/adc_responder.sv
// Emulates an 8-bit parallel ADC so the sequencer can run in loopback without the analog front end.
// Latency: EOC falls CONV_CYCLES clocks after the CONVST falling edge is sampled; Data lags RD by one clock.
// No backpressure: starts outside IDLE/READY are dropped, and those in CONVERT/READY are tallied in overrun_cnt.
module adc_responder #(
    parameter int unsigned CONV_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 16
) (
    input  logic       clk_10MHz,
    input  logic       reset,
    adc_if.slave       adc,
    input  logic [7:0] sample_in,
    input  logic       ramp_mode,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    typedef enum logic [2:0] {
        PWRDN   = 3'd0,
        WAKE    = 3'd1,
        IDLE    = 3'd2,
        CONVERT = 3'd3,
        READY   = 3'd4,
        READ    = 3'd5
    } state_e;

    // Counters are loaded with N-1 so the exit happens on the Nth edge.
    localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);
    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] result_q, result_d;
    logic [7:0] ramp_q, ramp_d;
    logic [7:0] ovr_q, ovr_d;
    logic [7:0] data_q, data_d;
    logic       eoc_q, eoc_d;
    logic       busy_q, busy_d;
    logic       prev_convst_q;
    logic       conv_start;
    logic [7:0] src;
    logic [7:0] ovr_inc;

    assign conv_start = prev_convst_q & ~adc.ADC_CONVST;
    assign src        = ramp_mode ? ramp_q : sample_in;
    assign ovr_inc    = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        result_d = result_q;
        ramp_d   = ramp_q;
        ovr_d    = ovr_q;
        eoc_d    = eoc_q;
        if (adc.ADC_PD) begin
            state_d = PWRDN;
            eoc_d   = 1'b1;
        end else begin
            case (state_q)
                PWRDN: begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end
                WAKE: begin
                    if (cnt_q == 8'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                IDLE: begin
                    if (conv_start) begin
                        shadow_d = src;
                        cnt_d    = CONV_LOAD;
                        state_d  = CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_start) ovr_d = ovr_inc;
                    if (cnt_q == 8'd0) begin
                        result_d = shadow_q;
                        eoc_d    = 1'b0;
                        ramp_d   = ramp_q + 8'd1;
                        state_d  = READY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                READY: begin
                    // A new start abandons the unread result and beats a coincident read.
                    if (conv_start) begin
                        ovr_d    = ovr_inc;
                        shadow_d = src;
                        cnt_d    = CONV_LOAD;
                        eoc_d    = 1'b1;
                        state_d  = CONVERT;
                    end else if (!adc.ADC_RD) begin
                        eoc_d   = 1'b1;
                        state_d = READ;
                    end
                end
                READ: begin
                    if (adc.ADC_RD) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        data_d = (adc.ADC_PD || adc.ADC_RD) ? 8'd0 : result_q;
        busy_d = (state_d == CONVERT) || (state_d == WAKE) || (state_d == PWRDN);
    end

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            shadow_q      <= 8'd0;
            result_q      <= 8'd0;
            ramp_q        <= 8'd0;
            ovr_q         <= 8'd0;
            data_q        <= 8'd0;
            eoc_q         <= 1'b1;
            busy_q        <= 1'b0;
            prev_convst_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            result_q      <= result_d;
            ramp_q        <= ramp_d;
            ovr_q         <= ovr_d;
            data_q        <= data_d;
            eoc_q         <= eoc_d;
            busy_q        <= busy_d;
            prev_convst_q <= adc.ADC_CONVST;
        end
    end

    assign adc.ADC_EOC = eoc_q;
    assign adc.Data    = data_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable emulator of the 8-bit parallel ADC that the sequencer FSM drives through ADC_CONVST, ADC_RD and ADC_PD.
- Answers with ADC_EOC and Data, so the sequencer can be exercised in loopback on the ZCU102 without the analog front end.
- Sits on the same clk_10MHz domain as the sequencer, so inputs need no synchronizers.
- Sample source is either an external sample bus or an internal ramp.

Parameters:
- CONV_CYCLES, 8, clocks from detected CONVST falling edge to ADC_EOC assertion (legal range 1..255).
- WAKE_CYCLES, 16, clocks spent waking up after ADC_PD deasserts (legal range 1..255).

Ports:
- clk_10MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ADC_CONVST  in  1  conversion start, active-low; falling edge starts a conversion.
- ADC_RD  in  1  read strobe, active-low.
- ADC_PD  in  1  power-down, active-high.
- sample_in  in  8  value captured at conversion start when ramp_mode=0.
- ramp_mode  in  1  1 = capture the internal ramp counter instead of sample_in.
- ADC_EOC  out  1  end of conversion, active-low.
- Data  out  8  conversion result.
- busy  out  1  high in CONVERT, WAKE and PWRDN.
- overrun_cnt  out  8  saturating count of rejected or overwritten conversions.

Behaviour:
- Reset (reset=0): state IDLE; ADC_EOC=1, Data=0, busy=0, overrun_cnt=0. Internal result=0, ramp=0, prev_convst=1. Reset mid-conversion discards the conversion.
- Edge detect: conv_start = prev_convst & ~ADC_CONVST. prev_convst is registered every clock.
- States: PWRDN, WAKE, IDLE, CONVERT, READY, READ.
- Priority: ADC_PD=1 overrides everything. From any state, the next state is PWRDN.
  - Any conversion in progress is aborted and not counted.
  - ADC_EOC=1 and Data=0 while in PWRDN. result and ramp are retained.
- PWRDN -> WAKE when ADC_PD=0.
- WAKE: down-counter loaded with WAKE_CYCLES. Goes to IDLE when the count expires. conv_start in WAKE is ignored and not counted.
- IDLE, conv_start seen at edge t: capture source (ramp_mode ? ramp : sample_in) into a shadow register, then go to CONVERT.
- CONVERT: at edge t+CONV_CYCLES, result <= shadow, ADC_EOC <= 0, ramp <= ramp+1 (8-bit wrap 255->0), state READY.
  - conv_start during CONVERT is ignored and overrun_cnt increments.
- READY, ADC_EOC held low:
  - ADC_RD=0 -> READ. ADC_EOC returns to 1 on the same edge.
  - conv_start -> unread result is abandoned; overrun_cnt increments; capture new sample; ADC_EOC <= 1; go to CONVERT.
  - conv_start and ADC_RD=0 in the same cycle: conv_start wins and the read is ignored.
- READ: stays while ADC_RD=0. Goes to IDLE when ADC_RD=1.
- Data output (registered, one clock latency): Data <= ADC_RD==0 ? result : 0, in every state except PWRDN, where Data=0. A read outside READY therefore returns the previous completed result; ADC_EOC is unaffected.
- overrun_cnt: saturates at 255 and never wraps. Cleared only by reset.
- busy: registered with the state. Equals 1 exactly in CONVERT, WAKE and PWRDN.
- Sequencer idle levels (ADC_CONVST=1, ADC_RD=1, ADC_PD=0) leave the block in IDLE with ADC_EOC=1, Data=0.

Test Plan:
- Basic conversion: release reset, sample_in=8'hA5, ramp_mode=0, drive ADC_CONVST 1->0 at edge 10.
  - Expect ADC_EOC=0 from edge 18, busy=1 during edges 10..17.
  - Pull ADC_RD low at edge 20: Data=8'hA5 at edge 21, ADC_EOC=1 at edge 21.
  - Release ADC_RD: Data=0 on the next edge.
- Ramp wrap: ramp_mode=1, perform 257 convert/read cycles. Expect read values 0,1,…,255,0, and overrun_cnt stays 0.
- Overrun: start a conversion, pulse ADC_CONVST low again 3 clocks later (in CONVERT), then again while in READY without reading.
  - Expect overrun_cnt=2, and ADC_EOC re-asserts CONV_CYCLES after the third start.
  - Drive 300 rejected starts and expect overrun_cnt stuck at 255.
- Power-down mid-conversion: ADC_PD=1 at 4 clocks into CONVERT. Expect busy=1, ADC_EOC=1, Data=0, result unchanged.
  - Release ADC_PD, then toggle ADC_CONVST during WAKE: expect no overrun increment and IDLE exactly 16 clocks after release.
- Simultaneous events in READY: assert conv_start and ADC_RD=0 on the same edge. Expect state CONVERT, overrun_cnt+1, and Data showing the old result.
- Async reset: assert reset low mid-READY, asynchronously between clock edges. Expect ADC_EOC=1, Data=0, overrun_cnt=0 immediately, without waiting for a clock edge.
